axis_frame_join_sched: RTL and testbench
========================================

Name: axis_frame_join_sched

Overview:
Scheduler placed in front of the S_COUNT-input AXI-stream frame joiner.
- Holds all inputs off until every port has a frame pending, or until a programmable timeout expires.
- On timeout, substitutes a one-word filler frame (tuser=1) for each absent port, so the joiner never stalls on a dead source.
- Drives the joiner's tag with an incrementing sequence number and reports per-join status.

Parameters:
S_COUNT, 4, number of input streams (≥1)
DATA_WIDTH, 8, tdata width per stream
TAG_WIDTH, 16, tag / sequence counter width
TIMEOUT_WIDTH, 16, timeout counter width

Ports:
clk  in  1  clock
rst  in  1  reset
s_axis_tdata  in  S_COUNT*DATA_WIDTH  source data
s_axis_tvalid  in  S_COUNT  source valid
s_axis_tready  out  S_COUNT  source ready
s_axis_tlast  in  S_COUNT  source last
s_axis_tuser  in  S_COUNT  source error flag
m_axis_tdata  out  S_COUNT*DATA_WIDTH  to joiner inputs
m_axis_tvalid  out  S_COUNT  to joiner
m_axis_tready  in  S_COUNT  from joiner
m_axis_tlast  out  S_COUNT  to joiner
m_axis_tuser  out  S_COUNT  to joiner
tag  out  TAG_WIDTH  tag for joiner, current sequence number
enable  in  1  allow new join to start
timeout  in  TIMEOUT_WIDTH  cycles to wait for all ports; 0 = wait forever
busy  out  1  join in progress
stat_join  out  1  one-cycle pulse, join completed
stat_timeout  out  1  one-cycle pulse, timeout fired
stat_missing  out  S_COUNT  ports filled on last timeout, held until next timeout

Behaviour:
- Single clock domain. Reset is synchronous, active-high. Clock port is clk; reset port is rst.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, tag=0, busy=0, stat_join=0, stat_timeout=0, stat_missing=0, state=IDLE, present mask=0, done mask=0.
- Reset mid-join aborts the join. Partially passed frames are not completed (the joiner is reset with the same rst).

State IDLE:
- All s_axis_tready and m_axis_tvalid are 0.
- If enable && |s_axis_tvalid: go to WAIT_ALL, load timer=timeout, present=s_axis_tvalid.

State WAIT_ALL:
- Update present |= s_axis_tvalid each cycle. No ready asserted.
- If present is all-ones (including the current cycle's tvalid): go to PASS next cycle, fill=0.
- Else if timeout!=0 and timer==1: go to PASS, fill=~present, pulse stat_timeout, stat_missing=~present.
- Else timer decrements. With timeout=N, the timeout fires exactly N cycles after WAIT_ALL entry.
- Deasserting enable after leaving IDLE has no effect on the current join.

State PASS, per port i:
- Present port: combinational pass-through.
  - m_axis_tvalid[i] = s_axis_tvalid[i] & ~done[i]
  - s_axis_tready[i] = m_axis_tready[i] & ~done[i]
  - data, last and user pass through unchanged.
- Filler port: m_axis_tvalid[i] = ~done[i], tdata=0, tlast=1, tuser=1. s_axis_tready[i]=0.
- done[i] sets on a tvalid&tready&tlast handshake on m_axis port i.
- When done becomes all-ones (registered): go to DONE.

State DONE (one cycle):
- Pulse stat_join, tag <= tag+1 (wraps modulo 2^TAG_WIDTH), clear present and done, return to IDLE.

Timing and boundary conditions:
- Minimum gap between joins: 2 idle cycles (DONE + IDLE).
- tag changes only in DONE, so it is stable for the whole join, including the joiner's tag-word phase.
- busy = (state != IDLE).
- A frame arriving on a port after it was filled is held (tready=0) and counted as present for the next join.
- Both conditions in the same cycle (all present and timer==1): all-present wins, no timeout pulse.
- S_COUNT=1: WAIT_ALL exits on the first cycle, and the timeout path is unreachable.

Decomposition:
- Package axis_join_sched_pkg:
  - state encoding localparams (IDLE=0, WAIT_ALL=1, PASS=2, DONE=3)
  - filler constants (fill data=0, fill tuser=1)
- Sub-module axis_join_port_gate: per-port pass/filler mux plus done flag, instantiated S_COUNT times via generate.
- The top level holds the FSM, timer, tag counter and status.

Test Plan:
- S_COUNT=4, timeout=0, all ports present frames of 3/1/2/4 words simultaneously → joiner output is tag 0x0000 followed by the 10 words in port order. stat_join pulses once. tag becomes 0x0001.
- Ports 0–2 valid, port 3 silent, timeout=20 → stat_timeout pulses exactly 20 cycles after WAIT_ALL entry. stat_missing=4'b1000. Port 3 receives filler (tdata=0x00, tlast=1, tuser=1), and the joined frame ends with tuser=1.
- Port 3 arrives on the same cycle timer==1 → no timeout pulse, stat_missing unchanged, normal join.
- m_axis_tready toggles 1-0 randomly for every port → no data lost or duplicated. s_axis_tready never asserted outside PASS.
- tag preset near wrap: run 0x10000 joins with TAG_WIDTH=16 (or TAG_WIDTH=4 with 17 joins) → tag wraps 0xF→0x0.
- rst asserted for 1 cycle during PASS → next cycle all outputs are at reset values, tag=0, busy=0. A subsequent join completes normally.

Source files
------------

// File: rtl/axis_frame_join_sched_pkg.sv
// Shared definitions for the frame-join scheduler.
// Contents: the scheduler state type and the constants that make up a filler
// word (the one-word frame substituted for a port that never showed up).
package axis_join_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ALL = 2'd1,
        PASS     = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

    // Filler word: every data bit at FILL_DATA_BIT, tlast and tuser raised.
    localparam logic FILL_DATA_BIT = 1'b0;
    localparam logic FILL_TLAST    = 1'b1;
    localparam logic FILL_TUSER    = 1'b1;

endpackage

// File: rtl/axis_frame_join_sched_port_gate.sv
// Per-port gate of the frame-join scheduler.
// Purpose: while the scheduler is passing a join, the gate either forwards the
// source stream (present port) or emits a one-word filler frame (absent port).
// It remembers when that port's frame has finished so that no second frame
// slips through within the same join.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   active_i                 scheduler is in its pass phase
//   fill_i                   this port gets a filler frame instead of source data
//   clear_i                  join finished, drop the done flag
//   s_t*_i / s_tready_o      source-side AXI-stream
//   m_t*_o / m_tready_i      joiner-side AXI-stream
//   done_o                   this port's frame (or filler) has been fully handed over
module axis_join_port_gate
    import axis_join_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active_i,
    input  logic                  fill_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] s_tdata_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    input  logic                  s_tlast_i,
    input  logic                  s_tuser_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic                  m_tuser_o,
    output logic                  done_o
);

    logic done_q;

    always_comb begin
        s_tready_o = 1'b0;
        m_tvalid_o = 1'b0;
        m_tdata_o  = s_tdata_i;
        m_tlast_o  = s_tlast_i;
        m_tuser_o  = s_tuser_i;
        if (active_i) begin
            if (fill_i) begin
                m_tvalid_o = ~done_q;
                m_tdata_o  = {DATA_WIDTH{FILL_DATA_BIT}};
                m_tlast_o  = FILL_TLAST;
                m_tuser_o  = FILL_TUSER;
            end else begin
                m_tvalid_o = s_tvalid_i & ~done_q;
                s_tready_o = m_tready_i & ~done_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            done_q <= 1'b0;
        end else if (m_tvalid_o && m_tready_i && m_tlast_o) begin
            done_q <= 1'b1;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/axis_frame_join_sched.sv
// Scheduler in front of an S_COUNT-input AXI-stream frame joiner.
// Purpose: hold all sources until every port has a frame pending (or a
// programmable timeout expires), substitute one-word filler frames for absent
// ports on timeout, drive the joiner tag with a sequence number and report
// per-join status.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axis_*                  S_COUNT source streams
//   m_axis_*                  S_COUNT streams to the joiner inputs
//   tag                       current sequence number, changes only between joins
//   enable                    allow a new join to start
//   timeout                   cycles to wait for all ports, 0 waits forever
//   busy                      a join is in progress
//   stat_join / stat_timeout  one-cycle pulses: join completed / timeout fired
//   stat_missing              ports filled on the most recent timeout
module axis_frame_join_sched
    import axis_join_sched_pkg::*;
#(
    parameter int S_COUNT       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int TAG_WIDTH     = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tuser,
    output logic [S_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [S_COUNT-1:0]            m_axis_tvalid,
    input  logic [S_COUNT-1:0]            m_axis_tready,
    output logic [S_COUNT-1:0]            m_axis_tlast,
    output logic [S_COUNT-1:0]            m_axis_tuser,
    output logic [TAG_WIDTH-1:0]          tag,
    input  logic                          enable,
    input  logic [TIMEOUT_WIDTH-1:0]      timeout,
    output logic                          busy,
    output logic                          stat_join,
    output logic                          stat_timeout,
    output logic [S_COUNT-1:0]            stat_missing
);

    sched_state_t             state_q;
    logic [TIMEOUT_WIDTH-1:0] timer_q;
    logic [S_COUNT-1:0]       present_q;
    logic [S_COUNT-1:0]       fill_q;
    logic [S_COUNT-1:0]       done_w;
    logic [S_COUNT-1:0]       stat_missing_q;
    logic [TAG_WIDTH-1:0]     tag_q;
    logic                     stat_join_q;
    logic                     stat_timeout_q;
    logic [S_COUNT-1:0]       present_now;
    logic                     pass_active;
    logic                     join_clear;

    // Ports whose tvalid shows up this very cycle already count as present,
    // so an all-present in the timer==1 cycle beats the timeout.
    assign present_now = present_q | s_axis_tvalid;
    assign pass_active = (state_q == PASS);
    assign join_clear  = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            present_q      <= '0;
            fill_q         <= '0;
            tag_q          <= '0;
            stat_join_q    <= 1'b0;
            stat_timeout_q <= 1'b0;
            stat_missing_q <= '0;
        end else begin
            stat_join_q    <= 1'b0;
            stat_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && (|s_axis_tvalid)) begin
                        state_q   <= WAIT_ALL;
                        timer_q   <= timeout;
                        present_q <= s_axis_tvalid;
                    end
                end
                WAIT_ALL: begin
                    present_q <= present_now;
                    if (&present_now) begin
                        state_q <= PASS;
                        fill_q  <= '0;
                    end else if ((timeout != '0) && (timer_q == TIMEOUT_WIDTH'(1))) begin
                        state_q        <= PASS;
                        fill_q         <= ~present_now;
                        stat_timeout_q <= 1'b1;
                        stat_missing_q <= ~present_now;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - TIMEOUT_WIDTH'(1);
                    end
                end
                PASS: begin
                    if (&done_w) begin
                        state_q     <= DONE;
                        stat_join_q <= 1'b1;
                    end
                end
                DONE: begin
                    tag_q     <= tag_q + TAG_WIDTH'(1);
                    present_q <= '0;
                    fill_q    <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < S_COUNT; g++) begin : g_port
        axis_join_port_gate #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_gate (
            .clk        (clk),
            .rst        (rst),
            .active_i   (pass_active),
            .fill_i     (fill_q[g]),
            .clear_i    (join_clear),
            .s_tdata_i  (s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .s_tvalid_i (s_axis_tvalid[g]),
            .s_tready_o (s_axis_tready[g]),
            .s_tlast_i  (s_axis_tlast[g]),
            .s_tuser_i  (s_axis_tuser[g]),
            .m_tdata_o  (m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .m_tvalid_o (m_axis_tvalid[g]),
            .m_tready_i (m_axis_tready[g]),
            .m_tlast_o  (m_axis_tlast[g]),
            .m_tuser_o  (m_axis_tuser[g]),
            .done_o     (done_w[g])
        );
    end

    assign tag          = tag_q;
    assign busy         = (state_q != IDLE);
    assign stat_join    = stat_join_q;
    assign stat_timeout = stat_timeout_q;
    assign stat_missing = stat_missing_q;

endmodule

// File: tb/tb_axis_frame_join_sched.sv
// Self-checking bench for axis_frame_join_sched: per-port source queues feed
// the DUT, expected joiner-side words are queued per port and compared as the
// DUT hands them over.
module tb_axis_frame_join_sched;

    localparam int S   = 4;
    localparam int DW  = 8;
    localparam int TW  = 4;
    localparam int TOW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [S*DW-1:0]   s_axis_tdata;
    logic [S-1:0]      s_axis_tvalid;
    logic [S-1:0]      s_axis_tready;
    logic [S-1:0]      s_axis_tlast;
    logic [S-1:0]      s_axis_tuser;
    logic [S*DW-1:0]   m_axis_tdata;
    logic [S-1:0]      m_axis_tvalid;
    logic [S-1:0]      m_axis_tready;
    logic [S-1:0]      m_axis_tlast;
    logic [S-1:0]      m_axis_tuser;
    logic [TW-1:0]     tag;
    logic              enable;
    logic [TOW-1:0]    timeout;
    logic              busy;
    logic              stat_join;
    logic              stat_timeout;
    logic [S-1:0]      stat_missing;

    always #5 clk = ~clk;

    axis_frame_join_sched #(
        .S_COUNT      (S),
        .DATA_WIDTH   (DW),
        .TAG_WIDTH    (TW),
        .TIMEOUT_WIDTH(TOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .tag          (tag),
        .enable       (enable),
        .timeout      (timeout),
        .busy         (busy),
        .stat_join    (stat_join),
        .stat_timeout (stat_timeout),
        .stat_missing (stat_missing)
    );

    // Words are {tuser, tlast, tdata}.
    logic [9:0]    src_q [S][$];
    logic [9:0]    exp_q [S][$];
    logic [S-1:0]  src_en;
    logic          rand_rdy;
    logic [TW-1:0] exp_tag;
    logic          busy_prev;
    int            checks;
    int            failures;
    int            cyc;
    int            n_join;
    int            n_timeout;
    int            rise_cyc;
    int            to_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns before posedge, return 1 ns after posedge.
    task automatic step();
        logic [9:0] got;
        @(negedge clk);
        for (int i = 0; i < S; i++) begin
            m_axis_tready[i] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (src_en[i] && src_q[i].size() > 0) begin
                s_axis_tvalid[i] = 1'b1;
                {s_axis_tuser[i], s_axis_tlast[i], s_axis_tdata[i*DW +: DW]} = src_q[i][0];
            end else begin
                s_axis_tvalid[i] = 1'b0;
                {s_axis_tuser[i], s_axis_tlast[i], s_axis_tdata[i*DW +: DW]} = '0;
            end
        end
        #4;
        cyc++;
        if (!busy) check("idle_out", 32'({s_axis_tready, m_axis_tvalid}), 32'(0));
        if (busy && !busy_prev) rise_cyc = cyc;
        busy_prev = busy;
        if (stat_timeout) begin
            n_timeout++;
            to_cyc = cyc;
        end
        if (stat_join) begin
            n_join++;
            check("tag_join", 32'(tag), 32'(exp_tag));
            exp_tag = exp_tag + TW'(1);
        end
        for (int i = 0; i < S; i++) begin
            if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                got = {m_axis_tuser[i], m_axis_tlast[i], m_axis_tdata[i*DW +: DW]};
                if (exp_q[i].size() == 0) check("m_extra", 32'(exp_q[i].size()), 32'(1));
                else check($sformatf("m_word_p%0d", i), 32'(got), 32'(exp_q[i].pop_front()));
            end
            if (s_axis_tvalid[i] && s_axis_tready[i]) void'(src_q[i].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_frame(input int port, input int len);
        logic [9:0] w;
        for (int k = 0; k < len; k++) begin
            w = {1'b0, (k == len - 1), 8'($urandom)};
            src_q[port].push_back(w);
            exp_q[port].push_back(w);
        end
    endtask

    task automatic run_join(input int budget);
        int n0;
        n0 = n_join;
        for (int k = 0; k < budget && n_join == n0; k++) step();
        check("join_seen", 32'(n_join - n0), 32'(1));
        step();
        step();
    endtask

    task automatic check_drained(input string name);
        for (int i = 0; i < S; i++) check(name, 32'(exp_q[i].size()), 32'(0));
    endtask

    initial begin
        int r0;
        checks = 0; failures = 0; cyc = 0; n_join = 0; n_timeout = 0;
        rise_cyc = 0; to_cyc = 0; exp_tag = '0; busy_prev = 1'b0;
        rst = 1'b1; enable = 1'b0; timeout = '0; src_en = '0; rand_rdy = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
        m_axis_tready = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_tag", 32'(tag), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_stats", 32'({stat_join, stat_timeout, stat_missing}), 32'(0));
        check("rst_hs", 32'({s_axis_tready, m_axis_tvalid}), 32'(0));

        // All four ports present at once, no timeout.
        enable = 1'b1;
        timeout = '0;
        add_frame(0, 3); add_frame(1, 1); add_frame(2, 2); add_frame(3, 4);
        src_en = '1;
        run_join(60);
        check("t1_tag", 32'(tag), 32'(1));
        check("t1_nto", 32'(n_timeout), 32'(0));
        check_drained("t1_drain");

        // Port 3 silent: timeout after 20 cycles, filler on port 3.
        src_en = 4'b0111;
        timeout = TOW'(20);
        add_frame(0, 2); add_frame(1, 3); add_frame(2, 1);
        exp_q[3].push_back({1'b1, 1'b1, 8'h00});
        run_join(100);
        check("t2_to_delay", 32'(to_cyc - rise_cyc), 32'(20));
        check("t2_nto", 32'(n_timeout), 32'(1));
        check("t2_missing", 32'(stat_missing), 32'(4'b1000));
        check("t2_tag", 32'(tag), 32'(2));
        check_drained("t2_drain");

        // Port 3 arrives exactly in the timer==1 cycle: all-present wins.
        add_frame(0, 1); add_frame(1, 2); add_frame(2, 1); add_frame(3, 2);
        r0 = rise_cyc;
        for (int k = 0; k < 10 && rise_cyc == r0; k++) step();
        check("t3_started", 32'(rise_cyc != r0), 32'(1));
        repeat (18) step();
        src_en[3] = 1'b1;
        run_join(100);
        check("t3_nto", 32'(n_timeout), 32'(1));
        check("t3_missing", 32'(stat_missing), 32'(4'b1000));
        check("t3_tag", 32'(tag), 32'(3));
        check_drained("t3_drain");

        // Random backpressure on every joiner input.
        timeout = '0;
        src_en = '1;
        rand_rdy = 1'b1;
        repeat (4) begin
            for (int i = 0; i < S; i++) add_frame(i, $urandom_range(1, 5));
            run_join(300);
        end
        rand_rdy = 1'b0;
        check("t4_tag", 32'(tag), 32'(7));
        check_drained("t4_drain");

        // Tag wraps modulo 16.
        repeat (12) begin
            for (int i = 0; i < S; i++) add_frame(i, 1);
            run_join(40);
        end
        check("t5_tag_wrap", 32'(tag), 32'(3));
        check("t5_njoin", 32'(n_join), 32'(19));

        // Reset in the middle of a pass.
        for (int i = 0; i < S; i++) add_frame(i, 6);
        for (int k = 0; k < 20 && m_axis_tvalid == '0; k++) step();
        check("t6_in_pass", 32'(m_axis_tvalid != '0), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_tag", 32'(tag), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_stats", 32'({stat_join, stat_timeout, stat_missing}), 32'(0));
        check("t6_hs", 32'({s_axis_tready, m_axis_tvalid}), 32'(0));
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        exp_tag = '0;
        for (int i = 0; i < S; i++) add_frame(i, 2);
        run_join(60);
        check("t6_tag_after", 32'(tag), 32'(1));
        check_drained("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
